mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one SRAM-style memory bus (req/addr_ok/data_ok) between the instruction-fetch port (I)
//  and the load/store port (D). Grants one request per cycle and tracks outstanding
//  transactions in an ordering FIFO, so in-order responses return to the issuing port.
//  Sits between the core's iram_*/dram_* ports and the single external memory interface.
// PARAMETERS
//  XLEN         32  data/address width
//  MAX_OUTST    2   max accepted-but-unanswered transactions (ordering FIFO depth, power of 2)
//  STARVE_LIMIT 4   consecutive D grants while I waits before I is forced to win
// PORTS
//  clk           in   1        core clock
//  rst_b         in   1        asynchronous active-low reset
//  i_req         in   1        I-port request (also i_write, i_wstrb, i_addr, i_wdata, same shape as D)
//  i_write       in   1        I-port write enable (normally 0)
//  i_wstrb       in   XLEN/8   I-port byte strobes
//  i_addr        in   XLEN     I-port address
//  i_wdata       in   XLEN     I-port write data
//  i_addr_ok     out  1        I-port request accepted this cycle
//  i_data_ok     out  1        I-port response valid this cycle
//  i_rdata       out  XLEN     I-port read data
//  d_req/d_write/d_wstrb/d_addr/d_wdata  in    D-port request, widths as I-port
//  d_addr_ok/d_data_ok  out  1  D-port accept / response
//  d_rdata       out  XLEN     D-port read data
//  bus_req/bus_write/bus_wstrb/bus_addr/bus_wdata  out  request to memory, widths as I-port
//  bus_addr_ok   in   1        memory accepted request
//  bus_data_ok   in   1        memory response valid
//  bus_rdata     in   XLEN     memory read data
//  err_rsp       out  1        sticky: bus_data_ok seen with empty ordering FIFO
// BEHAVIOUR
//  - Reset (rst_b=0, async): FIFO empty, lock=NONE, starve_cnt=0, err_rsp=0; all *_ok and bus_req 0.
//  - Lock state: NONE / LOCK_I / LOCK_D. In NONE, selection is D>I, except I wins when
//    starve_cnt==STARVE_LIMIT. bus_req asserts the selected request. If bus_addr_ok=0 that
//    cycle, lock is set to the winner and the same port is held on the bus until bus_addr_ok=1,
//    then returns to NONE. Masters keep requests stable until addr_ok.
//  - bus_* request fields are a combinational mux of the granted port. x_addr_ok = bus_addr_ok
//    & granted==x. Same-cycle accept possible (zero added latency).
//  - starve_cnt: +1 on each accepted D grant while i_req=1 (saturates); cleared on I accept
//    or when i_req=0.
//  - Ordering FIFO: push port ID on bus_req&bus_addr_ok; pop on bus_data_ok. Head ID routes
//    the response: x_data_ok = bus_data_ok & head==x; x_rdata = bus_rdata (both ports).
//  - Full (count==MAX_OUTST): bus_req=0 and no addr_ok to either port. Full is taken from
//    the registered count, so a pop in the same cycle does not unblock a push. Lock is kept.
//  - Empty with bus_data_ok: response dropped, no x_data_ok, err_rsp set until reset.
//  - Push and pop in the same cycle with count unchanged are legal. Pointers wrap mod MAX_OUTST.
//  - A data_ok for a response issued before reset mid-operation is dropped and flags err_rsp.
//    The memory side must share the reset.
// TESTING
//  - Only i_req=1, addr 0x100, bus_addr_ok=1 -> bus_addr=0x100, i_addr_ok=1 same cycle.
//    bus_data_ok 1 cycle later with rdata 0xDEADBEEF -> i_data_ok=1, i_rdata=0xDEADBEEF.
//  - i_req and d_req together (d_addr 0x200) -> D granted first. I is accepted the next cycle,
//    and the responses are routed D then I.
//  - d_req first with bus_addr_ok=0 for 3 cycles, then i_req raised -> bus stays on D
//    (LOCK_D) until accept, then I is granted.
//  - i_req and d_req held with always-ready bus -> after 4 D accepts, I is accepted on the
//    5th grant and starve_cnt resets.
//  - 2 accepted without response (MAX_OUTST=2) -> bus_req=0. A data_ok that cycle does not
//    allow a new accept until the next cycle.
//  - bus_data_ok with empty FIFO -> no port data_ok, err_rsp=1 and held. Async rst_b mid-burst
//    -> all outputs 0 immediately.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - I/D port arbiter onto one SRAM-style bus with in-order response routing
// A small ID FIFO remembers which port issued each accepted request so responses find their way back.
module mem_bus_arbiter #(
  parameter int XLEN         = 32,
  parameter int MAX_OUTST    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              i_req,
  input  logic              i_write,
  input  logic [XLEN/8-1:0] i_wstrb,
  input  logic [XLEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [XLEN/8-1:0] d_wstrb,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [XLEN-1:0]   d_rdata,
  output logic              bus_req,
  output logic              bus_write,
  output logic [XLEN/8-1:0] bus_wstrb,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [XLEN-1:0]   bus_rdata,
  output logic              err_rsp
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {LOCK_NONE, LOCK_I, LOCK_D} lock_e;

  lock_e              lock_q, lock_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [MAX_OUTST-1:0] id_q, id_d;  // 1 = D port, 0 = I port
  logic [STV_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               err_rsp_q, err_rsp_d;

  logic sel_i, sel_d, grant_i, grant_d;
  logic full, empty, accept, pop;

  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    case (lock_q)
      LOCK_I:  sel_i = i_req;
      LOCK_D:  sel_d = d_req;
      default: begin
        if (d_req && !(i_req && starve_cnt_q == STV_W'(STARVE_LIMIT))) sel_d = 1'b1;
        else if (i_req) sel_i = 1'b1;
      end
    endcase
  end

  // Outputs must fall immediately on reset assertion, hence the rst_b gate.
  assign full    = (count_q == CNT_W'(MAX_OUTST));
  assign empty   = (count_q == '0);
  assign grant_i = rst_b & ~full & sel_i;
  assign grant_d = rst_b & ~full & sel_d;
  assign accept  = bus_req & bus_addr_ok;
  assign pop     = bus_data_ok & ~empty;

  assign bus_req   = grant_i | grant_d;
  assign bus_write = sel_d ? d_write : i_write;
  assign bus_wstrb = sel_d ? d_wstrb : i_wstrb;
  assign bus_addr  = sel_d ? d_addr  : i_addr;
  assign bus_wdata = sel_d ? d_wdata : i_wdata;

  assign i_addr_ok = grant_i & bus_addr_ok;
  assign d_addr_ok = grant_d & bus_addr_ok;
  assign i_data_ok = pop & ~id_q[rd_ptr_q];
  assign d_data_ok = pop &  id_q[rd_ptr_q];
  assign i_rdata   = bus_rdata;
  assign d_rdata   = bus_rdata;
  assign err_rsp   = err_rsp_q;

  always_comb begin
    lock_d       = lock_q;
    count_d      = count_q + CNT_W'(accept) - CNT_W'(pop);
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    id_d         = id_q;
    starve_cnt_d = starve_cnt_q;
    err_rsp_d    = err_rsp_q | (bus_data_ok & empty);

    // While full the bus is idle by force, so the pending winner keeps its lock.
    if (!full) begin
      if (bus_req && !bus_addr_ok) lock_d = grant_d ? LOCK_D : LOCK_I;
      else                         lock_d = LOCK_NONE;
    end

    if (accept) begin
      id_d[wr_ptr_q] = grant_d;
      wr_ptr_d       = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (!i_req || (accept && grant_i))
      starve_cnt_d = '0;
    else if (accept && grant_d && starve_cnt_q != STV_W'(STARVE_LIMIT))
      starve_cnt_d = starve_cnt_q + STV_W'(1);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lock_q       <= LOCK_NONE;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      id_q         <= '0;
      starve_cnt_q <= '0;
      err_rsp_q    <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      id_q         <= id_d;
      starve_cnt_q <= starve_cnt_d;
      err_rsp_q    <= err_rsp_d;
    end
  end

endmodule
